// File: rtl/calc_pkg.sv
// Shared definitions for the UART ALU path: opcodes, digit width and the
// expression-assembler state encoding.
package calc_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OPC_W-1:0] OP_MUL = 4'b0010;
    localparam logic [OPC_W-1:0] OP_REM = 4'b0100;
    localparam logic [OPC_W-1:0] OP_DIV = 4'b1000;
    localparam logic [OPC_W-1:0] OP_EQ  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPA,
        ST_OPB_WAIT,
        ST_OPB,
        ST_ISSUE
    } state_t;

    function automatic logic is_valid_op(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_REM) || (op == OP_DIV) || (op == OP_EQ);
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulate step: old*10 + digit, flagging digit-count or range overflow.
module dec_accum
    import calc_pkg::*;
#(
    parameter int unsigned OPER_W     = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic [OPER_W-1:0]                 old_val,
    input  logic [$clog2(MAX_DIGITS + 1)-1:0] cnt,
    input  logic [DIGIT_W-1:0]                digit,
    output logic [OPER_W-1:0]                 sum_c,
    output logic                              ovf_c
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int unsigned ACC_W = OPER_W + 4;

    logic [ACC_W-1:0] wide_c;

    // Four guard bits hold (2^OPER_W-1)*10+9 without wrapping.
    assign wide_c = ACC_W'(old_val) * ACC_W'(10) + ACC_W'(digit);
    assign sum_c  = wide_c[OPER_W-1:0];
    assign ovf_c  = (cnt == CNT_W'(MAX_DIGITS)) || (wide_c[ACC_W-1:OPER_W] != '0);

endmodule

// File: rtl/expr_assembler.sv
// Builds {A, op, B} from digit/operator strobes and hands it to the ALU on '='.
module expr_assembler
    import calc_pkg::*;
#(
    parameter int unsigned OPER_W     = 16,
    parameter int unsigned MAX_DIGITS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              num_done,
    input  logic [7:0]        num_i,
    input  logic              oper_done,
    input  logic [OPC_W-1:0]  oper_i,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [OPER_W-1:0] alu_a,
    output logic [OPER_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_op,
    output logic              err,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

    state_t             state_q, state_d;
    logic [OPER_W-1:0]  a_q, a_d, b_q, b_d;
    logic [OPC_W-1:0]   op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_d, valid_d, clear_d;
    logic [OPER_W-1:0]  alu_a_d, alu_b_d;
    logic [OPC_W-1:0]   alu_op_d;

    logic [OPER_W-1:0]  acc_old_c, acc_sum_c;
    logic               acc_ovf_c;
    logic               proto_err_c, is_eq_c, handshake_c;
    logic [DIGIT_W-1:0] digit_c;

    assign digit_c     = num_i[DIGIT_W-1:0];
    assign acc_old_c   = (state_q == ST_OPB) ? b_q : a_q;
    assign is_eq_c     = (oper_i == OP_EQ);
    assign handshake_c = alu_valid && alu_ready;
    assign proto_err_c = (num_done && oper_done) ||
                         (num_done && (num_i > 8'd9)) ||
                         (oper_done && !is_valid_op(oper_i));

    dec_accum #(
        .OPER_W     (OPER_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_dec_accum (
        .old_val (acc_old_c),
        .cnt     (cnt_q),
        .digit   (digit_c),
        .sum_c   (acc_sum_c),
        .ovf_c   (acc_ovf_c)
    );

    // Next-state, operand update and registered-output preparation.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        clear_d = 1'b0;

        if (state_q == ST_ISSUE) begin
            err_d   = num_done || oper_done;
            clear_d = handshake_c;
        end else if (proto_err_c) begin
            err_d   = 1'b1;
            clear_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (num_done) begin
                        a_d     = OPER_W'(digit_c);
                        cnt_d   = CNT_W'(1);
                        state_d = ST_OPA;
                    end else if (oper_done && !is_eq_c) begin
                        err_d   = 1'b1;
                        clear_d = 1'b1;
                    end
                end
                ST_OPA: begin
                    if (num_done) begin
                        if (acc_ovf_c) begin
                            err_d   = 1'b1;
                            clear_d = 1'b1;
                        end else begin
                            a_d   = acc_sum_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (oper_done) begin
                        if (is_eq_c) begin
                            err_d   = 1'b1;
                            clear_d = 1'b1;
                        end else begin
                            op_d    = oper_i;
                            state_d = ST_OPB_WAIT;
                        end
                    end
                end
                ST_OPB_WAIT: begin
                    if (num_done) begin
                        b_d     = OPER_W'(digit_c);
                        cnt_d   = CNT_W'(1);
                        state_d = ST_OPB;
                    end else if (oper_done) begin
                        if (is_eq_c) begin
                            err_d   = 1'b1;
                            clear_d = 1'b1;
                        end else begin
                            op_d = oper_i;
                        end
                    end
                end
                ST_OPB: begin
                    if (num_done) begin
                        if (acc_ovf_c) begin
                            err_d   = 1'b1;
                            clear_d = 1'b1;
                        end else begin
                            b_d   = acc_sum_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else if (oper_done) begin
                        if (is_eq_c) begin
                            state_d = ST_ISSUE;
                        end else begin
                            err_d   = 1'b1;
                            clear_d = 1'b1;
                        end
                    end
                end
                default: clear_d = 1'b1;
            endcase
        end

        if (clear_d) begin
            state_d = ST_IDLE;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            cnt_d   = '0;
        end

        // Valid lags entry into ISSUE by one cycle; payload is loaded on entry.
        valid_d  = (state_q == ST_ISSUE) && !handshake_c;
        alu_a_d  = (state_d == ST_ISSUE) ? a_d  : '0;
        alu_b_d  = (state_d == ST_ISSUE) ? b_d  : '0;
        alu_op_d = (state_d == ST_ISSUE) ? op_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            alu_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            alu_valid <= valid_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_op    <= alu_op_d;
            err       <= err_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_expr_assembler.sv
// Scoreboard bench for expr_assembler: digit-list reference model feeds queues
// that a negedge monitor checks against err and the ALU handshake.
module tb_expr_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        num_done = 1'b0;
    logic [7:0]  num_i = 8'd0;
    logic        oper_done = 1'b0;
    logic [3:0]  oper_i = 4'd0;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        err, busy;

    expr_assembler #(.OPER_W(16), .MAX_DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .num_done  (num_done),
        .num_i     (num_i),
        .oper_done (oper_done),
        .oper_i    (oper_i),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } txn_t;

    txn_t txn_q[$];
    int   err_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int       a_dig[$];
    int       b_dig[$];
    bit       m_have_op = 1'b0;
    bit       m_issuing = 1'b0;
    logic [3:0] m_op = 4'd0;
    int       m_age = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint val(input int q[$]);
        longint v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    function automatic void m_clear();
        a_dig.delete();
        b_dig.delete();
        m_have_op = 1'b0;
    endfunction

    function automatic bit m_busy();
        return m_issuing || (a_dig.size() != 0);
    endfunction

    // Reference model: returns whether this strobe cycle must raise err.
    function automatic bit model(input bit nd, input int n, input bit od, input int o);
        bit   eq;
        txn_t t;
        if (m_issuing) return nd || od;
        if (!nd && !od) return 1'b0;
        if ((nd && od) || (nd && n > 9) ||
            (od && !(o inside {0, 1, 2, 4, 8, 15}))) begin
            m_clear();
            return 1'b1;
        end
        if (nd) begin
            if (!m_have_op) begin
                a_dig.push_back(n);
                if (a_dig.size() > 5 || val(a_dig) > 65535) begin m_clear(); return 1'b1; end
            end else begin
                b_dig.push_back(n);
                if (b_dig.size() > 5 || val(b_dig) > 65535) begin m_clear(); return 1'b1; end
            end
            return 1'b0;
        end
        eq = (o == 15);
        if (a_dig.size() == 0) begin
            if (eq) return 1'b0;
            m_clear();
            return 1'b1;
        end
        if (!m_have_op || b_dig.size() == 0) begin
            if (eq) begin m_clear(); return 1'b1; end
            m_have_op = 1'b1;
            m_op = 4'(o);
            return 1'b0;
        end
        if (!eq) begin m_clear(); return 1'b1; end
        t.a  = 16'(val(a_dig));
        t.b  = 16'(val(b_dig));
        t.op = m_op;
        txn_q.push_back(t);
        m_clear();
        m_issuing = 1'b1;
        m_age = 0;
        return 1'b0;
    endfunction

    // One stimulus cycle: check state-derived outputs, drive, update the model.
    task automatic cycle(input bit nd, input int n, input bit od, input int o, input bit rdy);
        bit e;
        @(posedge clk);
        #1;
        if (m_issuing) m_age++;
        chk("busy", busy, m_busy());
        chk("valid_timing", alu_valid, m_issuing && m_age >= 2);
        num_done  = nd;
        num_i     = 8'(n);
        oper_done = od;
        oper_i    = 4'(o);
        alu_ready = rdy;
        e = model(nd, n, od, o);
        if (e) err_q.push_back(cyc);
        if (m_issuing && m_age >= 2 && rdy) m_issuing = 1'b0;
    endtask

    task automatic dig(input int d);
        cycle(1'b1, d, 1'b0, 0, 1'b0);
    endtask

    task automatic opr(input int o);
        cycle(1'b0, 0, 1'b1, o, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Keep ready low for lo cycles of valid, optionally inject a digit in ISSUE.
    task automatic finish_issue(input int lo, input bit inject);
        bit r;
        for (int i = 0; i < 40 && m_issuing; i++) begin
            r = (m_age + 1 >= 2 + lo);
            if (inject && i == 1) cycle(1'b1, 9, 1'b0, 0, r);
            else                  cycle(1'b0, 0, 1'b0, 0, r);
        end
        chk("handshake_done", m_issuing, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        num_done = 1'b0; oper_done = 1'b0; alu_ready = 1'b0;
        txn_q.delete();
        err_q.delete();
        m_clear();
        m_issuing = 1'b0;
        m_age = 0;
        #2;
        chk("rst_valid", alu_valid, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: err pulses and the ALU payload against the scoreboard queues.
    always @(negedge clk) begin
        bit   exp_err;
        txn_t t;
        exp_err = 1'b0;
        while (err_q.size() > 0 && err_q[0] < cyc - 1) void'(err_q.pop_front());
        if (err_q.size() > 0 && err_q[0] == cyc - 1) begin
            exp_err = 1'b1;
            void'(err_q.pop_front());
        end
        chk("err", err, exp_err);
        if (alu_valid) begin
            if (txn_q.size() == 0) begin
                chk("valid_spurious", alu_valid, 0);
            end else begin
                t = txn_q[0];
                chk("alu_a", alu_a, t.a);
                chk("alu_b", alu_b, t.b);
                chk("alu_op", alu_op, t.op);
                if (alu_ready) void'(txn_q.pop_front());
            end
        end
    end

    localparam int OPS[5] = '{0, 1, 2, 4, 8};

    initial begin
        int na, nb, d;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", alu_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_err", err, 0);
        rst = 1'b0;

        // Basic expression with back-pressure
        dig(1); dig(2); opr(0); dig(3); dig(4); opr(15);
        finish_issue(3, 1'b0);
        idle(); idle();

        // Operand range and digit count limits
        dig(6); dig(5); dig(5); dig(3); dig(5); opr(2); dig(2); opr(15);
        finish_issue(0, 1'b0);
        dig(6); dig(5); dig(5); dig(3); dig(6); idle();
        dig(1); dig(2); dig(3); dig(4); dig(5); dig(6); idle();
        dig(0); dig(0); dig(0); dig(0); dig(7); dig(1); idle();

        // Last operator wins
        dig(7); opr(0); opr(1); dig(3); opr(15);
        finish_issue(1, 1'b0);

        // Malformed input
        opr(15); idle();
        opr(0); idle();
        dig(5); opr(15); idle();
        dig(5); opr(0); opr(15); idle();
        dig(5); opr(0); dig(3); opr(1); idle();
        dig(2); cycle(1'b1, 3, 1'b1, 0, 1'b0); idle();
        opr(3); idle();
        dig(12); idle();

        // Reset mid-expression and mid-handshake
        dig(1); dig(2); opr(0); dig(3);
        do_reset();
        dig(4); opr(8); dig(2); opr(15); idle(); idle();
        do_reset();
        dig(4); opr(8); dig(2); opr(15);
        finish_issue(0, 1'b0);

        // Strobe dropped during ISSUE
        dig(8); opr(4); dig(9); opr(15);
        finish_issue(3, 1'b1);

        // Randomized expressions with occasional malformed strobes
        for (int k = 0; k < 150; k++) begin
            na = $urandom_range(1, 6);
            for (int i = 0; i < na; i++) begin
                d = ($urandom_range(0, 39) == 0) ? $urandom_range(10, 255) : $urandom_range(0, 9);
                dig(d);
                if ($urandom_range(0, 3) == 0) idle();
            end
            opr(OPS[$urandom_range(0, 4)]);
            if ($urandom_range(0, 4) == 0) opr(OPS[$urandom_range(0, 4)]);
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) dig($urandom_range(0, 9));
            case ($urandom_range(0, 9))
                0: opr($urandom_range(0, 15));
                1: cycle(1'b1, $urandom_range(0, 9), 1'b1, 15, 1'b0);
                default: ;
            endcase
            opr(15);
            if (m_issuing) finish_issue($urandom_range(0, 4), $urandom_range(0, 3) == 0);
        end

        repeat (4) idle();
        chk("txn_left", txn_q.size(), 0);
        chk("err_left", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/expr_assembler.md
Name: expr_assembler

Overview:
Downstream stage of the ASCII-to-binary decoder in the UART ALU path. It consumes single-cycle digit strobes (binary 0-9) and operator strobes (4-bit opcode) and builds decimal operands A and B and an operator. On '=' it presents {A, op, B} to the ALU over a valid/ready handshake. It detects malformed input and reports it, then resynchronises to a fresh expression.

Parameters:
OPER_W, 16, operand width in bits; operands are unsigned 0..2^OPER_W-1.
MAX_DIGITS, 5, maximum decimal digits accepted per operand.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
num_done  in  1  one-cycle strobe: num_i is valid
num_i  in  8  binary digit, 0..9
oper_done  in  1  one-cycle strobe: oper_i is valid
oper_i  in  4  opcode: ADD 0000, SUB 0001, MUL 0010, REM 0100, DIV 1000, EQ 1111
alu_valid  out  1  request to ALU
alu_ready  in  1  ALU accepts when alu_valid & alu_ready
alu_a  out  OPER_W  operand A
alu_b  out  OPER_W  operand B
alu_op  out  4  opcode; never EQ
err  out  1  one-cycle pulse: malformed input
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; A, B, op and the digit count are 0; alu_valid=0, alu_a=0, alu_b=0, alu_op=0, err=0, busy=0. Reset mid-expression or mid-handshake discards everything and drops alu_valid immediately.
- States: IDLE, OPA, OPB_WAIT, OPB, ISSUE.
- IDLE:
  - digit d: A=d, cnt=1, go to OPA.
  - EQ: ignored.
  - other opcode: err.
- OPA:
  - digit: accumulate into A.
  - non-EQ opcode: op latched, go to OPB_WAIT.
  - EQ: err.
- OPB_WAIT:
  - digit d: B=d, cnt=1, go to OPB.
  - non-EQ opcode: replaces op (last wins), stay.
  - EQ: err.
- OPB:
  - digit: accumulate into B.
  - EQ: go to ISSUE.
  - non-EQ opcode: err (no chaining).
- ISSUE:
  - alu_valid=1; alu_a/alu_b/alu_op held stable until the handshake.
  - When alu_valid & alu_ready at a clock edge: next cycle alu_valid=0, state IDLE, A/B/op cleared.
  - Any strobe while in ISSUE: dropped, err pulsed, state unchanged.
- Latency: EQ strobe at edge N gives alu_valid=1 after edge N+1. A ready already high completes at edge N+2, so the minimum valid pulse is 1 cycle.
- Accumulate rule:
  - new = old*10 + d, computed at OPER_W+4 bits.
  - err if cnt == MAX_DIGITS or new > 2^OPER_W-1; otherwise store new and increment cnt.
  - Leading zeros count as digits.
- Error action: err=1 for exactly one cycle (the cycle after the offending strobe); next state IDLE; A, B, op, cnt cleared.
- Protocol violations, all handled as err:
  - num_done & oper_done in the same cycle.
  - num_i > 9.
  - oper_i not in the opcode list.
- Divide/remainder by zero is not checked here; it belongs to the ALU.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package calc_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_REM, OP_DIV, OP_EQ;
  - digit width;
  - state encoding for the FSM.
- One sub-module, dec_accum: combinational multiply-by-10-plus-digit with overflow flag, parameterised by OPER_W and MAX_DIGITS. It is instantiated once and muxed onto A or B by state.

Test Plan:
1. Digits 1,2, ADD, digits 3,4, EQ, alu_ready low for 3 cycles then high -> alu_valid rises 1 cycle after EQ with a=12, b=34, op=0000; values stable for 4 cycles; alu_valid=0 and busy=0 after the handshake.
2. Digits 6,5,5,3,5, MUL, 2, EQ -> a=65535, b=2, op=0010. Separately, 6,5,5,3,6 -> err on the fifth digit, busy=0. Separately, 1,2,3,4,5,6 -> err on the sixth digit.
3. Digit 7, ADD, SUB, digit 3, EQ -> a=7, b=3, op=0001 (last operator wins).
4. Malformed input:
   - EQ in IDLE -> no err, stays IDLE.
   - ADD in IDLE -> err.
   - 5, EQ -> err.
   - 5, ADD, EQ -> err.
   - 5, ADD, 3, SUB -> err.
   - Simultaneous num_done & oper_done -> err.
   - oper_i=0011 -> err.
5. rst pulsed after 1, 2, ADD, 3 (and again while alu_valid=1) -> all outputs 0. Then 4, DIV, 2, EQ -> a=4, b=2, op=1000.
6. During ISSUE with alu_ready=0, inject digit 9 -> err pulse; alu_a/alu_b unchanged; handshake then completes normally.
